// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Request/result bundle between the execute-stage issue logic (master) and
//   the ALU execution unit (slave).
//
//   Handshake: a request transfers on a rising clock edge where both
//   req_valid_i and req_ready_o are 1. The master holds req_valid_i and the
//   request fields stable until that edge. There is no back-pressure on the
//   result side: result_valid_o is a one-cycle pulse. result_o, zero_o,
//   overflow_o and illegal_o hold their last values between pulses.
//
//   Signals:
//     req_valid_i     master -> slave  request valid
//     req_ready_o     slave  -> master unit can accept this cycle
//     ALU_control_i   master -> slave  ALU control code
//     a_i, b_i        master -> slave  operands (a_i carries the DSLLV amount)
//     result_valid_o  slave  -> master one-cycle result pulse
//     result_o        slave  -> master result
//     zero_o          slave  -> master result_o == 0
//     overflow_o      slave  -> master signed overflow (ADD/SUB)
//     illegal_o       slave  -> master unknown op code was accepted
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 4
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [CTRL_WIDTH-1:0] ALU_control_i;
   logic [DATA_WIDTH-1:0] a_i;
   logic [DATA_WIDTH-1:0] b_i;
   logic                  result_valid_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  zero_o;
   logic                  overflow_o;
   logic                  illegal_o;

   modport master (
      output req_valid_i, ALU_control_i, a_i, b_i,
      input  req_ready_o, result_valid_o, result_o, zero_o, overflow_o, illegal_o
   );

   modport slave (
      input  req_valid_i, ALU_control_i, a_i, b_i,
      output req_ready_o, result_valid_o, result_o, zero_o, overflow_o, illegal_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Consumes the ALU control code and two operands and
//   produces a registered result with zero, signed-overflow and illegal-op
//   flags. ADD/SUB/AND/OR/SLT complete in one cycle (result pulse the cycle
//   after accept). DSLLV (b << a[SHAMT_WIDTH-1:0]) uses an iterative
//   1-bit-per-cycle shifter: amount k>0 takes k+1 cycles and holds
//   req_ready_o low while the shift runs.
//
//   Build option: define ALU_FAST_SHIFT_EN to replace the iterative shifter
//   with a combinational barrel shifter; then every op has latency 1 and the
//   SHIFT state is never entered. Results are identical in both builds.
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        asynchronous active-high reset
//     bus          alu_exec_unit_if.slave (request + result signals)
//     dbg_state_o  FSM state for observation: 0 = IDLE, 1 = SHIFT
// ---------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_WIDTH  = 64,
   parameter int SHAMT_WIDTH = 6,
   parameter int CTRL_WIDTH  = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   alu_exec_unit_if.slave bus,
   output logic           dbg_state_o
);
   localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(4'b0000);
   localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(4'b0001);
   localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(4'b0010);
   localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(4'b0110);
   localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(4'b0111);
   localparam logic [CTRL_WIDTH-1:0] OP_DSLLV = CTRL_WIDTH'(4'b1000);
   localparam int                    MSB      = DATA_WIDTH - 1;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   state_e                 state;
   logic                   ready_q;
   logic                   valid_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic                   zero_q;
   logic                   ovf_q;
   logic                   ill_q;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic [SHAMT_WIDTH-1:0] cnt_q;

   logic [DATA_WIDTH-1:0]  a, b, sum, diff, res_d, shift_nx;
   logic [SHAMT_WIDTH-1:0] amt;
   logic                   ovf_d, ill_d, accept, start_shift;

   assign a        = bus.a_i;
   assign b        = bus.b_i;
   assign amt      = bus.a_i[SHAMT_WIDTH-1:0];
   assign sum      = a + b;
   assign diff     = a - b;
   assign shift_nx = shift_q << 1;
   assign accept   = bus.req_valid_i && ready_q;

`ifdef ALU_FAST_SHIFT_EN
   assign start_shift = 1'b0;
`else
   // Only a non-zero amount needs the iterative path; amount 0 is just b.
   assign start_shift = accept && (bus.ALU_control_i == OP_DSLLV) && (amt != '0);
`endif

   // Single-cycle result path.
   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      ill_d = 1'b0;
      case (bus.ALU_control_i)
         OP_ADD: begin
            res_d = sum;
            // Same-sign operands producing a result of the other sign.
            ovf_d = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            res_d = diff;
            // Opposite-sign operands where the result sign departs from a.
            ovf_d = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND: res_d = a & b;
         OP_OR:  res_d = a | b;
         OP_SLT: res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
         OP_DSLLV: res_d = b << amt;
`else
         // Only reaches the output for amount 0; other amounts go via SHIFT.
         OP_DSLLV: res_d = b;
`endif
         default: ill_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
         shift_q  <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_shift) begin
                  shift_q <= b;
                  cnt_q   <= amt;
                  ready_q <= 1'b0;
                  state   <= SHIFT;
               end else if (accept) begin
                  result_q <= res_d;
                  zero_q   <= (res_d == '0);
                  ovf_q    <= ovf_d;
                  ill_q    <= ill_d;
                  valid_q  <= 1'b1;
               end
            end
            SHIFT: begin
               shift_q <= shift_nx;
               cnt_q   <= cnt_q - 1'b1;
               // Last step: counter goes 1 -> 0, publish the shifted value.
               if (cnt_q == SHAMT_WIDTH'(1)) begin
                  result_q <= shift_nx;
                  zero_q   <= (shift_nx == '0);
                  ovf_q    <= 1'b0;
                  ill_q    <= 1'b0;
                  valid_q  <= 1'b1;
                  ready_q  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready_o    = ready_q;
   assign bus.result_valid_o = valid_q;
   assign bus.result_o       = result_q;
   assign bus.zero_o         = zero_q;
   assign bus.overflow_o     = ovf_q;
   assign bus.illegal_o      = ill_q;
   assign dbg_state_o        = (state == SHIFT);
endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Self-checking bench for alu_exec_unit (default iterative-shift build).
//   Expected results are queued when a request is accepted and compared when
//   the unit pulses result_valid_o, together with the cycle of the pulse.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
   localparam int DW = 64;
   localparam int EW = DW + 3;   // {result, zero, overflow, illegal}

   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLL = 4'b1000;

   logic clk = 1'b0;
   logic rst;
   logic dbg_state;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_pulse = 0;

   logic [EW-1:0] exp_q[$];
   int            cyc_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_unit_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(4)) bus ();

   alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(6), .CTRL_WIDTH(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   function automatic logic [EW-1:0] model(input logic [3:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic [DW:0]   s;
      logic [DW-1:0] r;
      logic          o, i;
      r = '0; o = 1'b0; i = 1'b0; s = '0;
      case (c)
         C_ADD: begin s = {a[DW-1], a} + {b[DW-1], b}; r = s[DW-1:0]; o = s[DW] ^ s[DW-1]; end
         C_SUB: begin s = {a[DW-1], a} - {b[DW-1], b}; r = s[DW-1:0]; o = s[DW] ^ s[DW-1]; end
         C_AND: r = a & b;
         C_OR:  r = a | b;
         C_SLT: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         C_SLL: r = b << a[5:0];
         default: i = 1'b1;
      endcase
      return {r, (r == '0), o, i};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && bus.result_valid_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: got result %0h expected no pulse (t=%0t)",
                     bus.result_o, $time);
         end else begin
            logic [EW-1:0] e;
            int            ec;
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            check($sformatf("pulse%0d_fields", n_pulse),
                  {bus.result_o, bus.zero_o, bus.overflow_o, bus.illegal_o}, e);
            check($sformatf("pulse%0d_cycle", n_pulse), cyc, ec);
            n_pulse++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [EW-1:0] e, input int lat, input bit push);
      int guard;
      guard = 0;
      bus.req_valid_i   = 1'b1;
      bus.ALU_control_i = c;
      bus.a_i           = a;
      bus.b_i           = b;
      while (!bus.req_ready_o && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) fail_now("send_wait_ready");
      else if (push) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc + 1 + lat);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      bus.req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      idle();
      while (exp_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain");
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]    ctrl;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] res;
      logic          z, o, i;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int lat;
      logic [3:0]    rc;
      logic [DW-1:0] ra, rb;
      logic [3:0]    ops[10];

      vecs[0]  = '{C_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{C_SUB, 64'd3, 64'd3, 64'd0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{C_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{C_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{C_OR,  64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'b1111, 64'd1, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{4'b0011, 64'd1, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{C_AND, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{C_SLL, 64'd0, 64'hAB, 64'hAB, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{C_SLL, 64'h43, 64'hF, 64'h78, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{C_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{C_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{C_SLT, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{C_SLL, 64'd63, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0};

      ops = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SLL, C_ADD, C_SUB, 4'b0011, 4'b1111};

      // ---- reset state ----
      rst               = 1'b1;
      bus.req_valid_i   = 1'b0;
      bus.ALU_control_i = '0;
      bus.a_i           = '0;
      bus.b_i           = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {bus.req_ready_o, bus.result_valid_o, bus.result_o, bus.zero_o,
             bus.overflow_o, bus.illegal_o, dbg_state},
            {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", bus.req_ready_o, 1'b1);

      // ---- table: applied back to back ----
      for (int i = 0; i < 16; i++) begin
         lat = (vecs[i].ctrl == C_SLL) ? int'(vecs[i].a[5:0]) : 0;
         send(vecs[i].ctrl, vecs[i].a, vecs[i].b,
              {vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].i}, lat, 1'b1);
      end
      drain();
      repeat (2) @(negedge clk);
      check("output_hold",
            {bus.result_valid_o, bus.result_o, bus.zero_o, bus.overflow_o, bus.illegal_o},
            {1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0});

      // ---- DSLLV amount 4 with a request held during the shift ----
      begin
         int low;
         send(C_SLL, 64'd4, 64'd1, {64'h10, 1'b0, 1'b0, 1'b0}, 4, 1'b1);
         check("shift_state_entered", dbg_state, 1'b1);
         bus.req_valid_i   = 1'b1;
         bus.ALU_control_i = C_ADD;
         bus.a_i           = 64'd2;
         bus.b_i           = 64'd3;
         low = 0;
         while (!bus.req_ready_o && low < 200) begin
            low++;
            @(negedge clk);
         end
         check("dsllv4_ready_low_cycles", low, 4);
         send(C_ADD, 64'd2, 64'd3, {64'd5, 1'b0, 1'b0, 1'b0}, 0, 1'b1);
         drain();
      end

      // ---- reset during a 40-bit shift, in its 10th SHIFT cycle ----
      send(C_SLL, 64'd40, 64'd1, '0, 0, 1'b0);
      idle();
      repeat (9) @(negedge clk);
      check("pre_reset_in_shift", {dbg_state, bus.req_ready_o}, {1'b1, 1'b0});
      rst = 1'b1;
      #1;
      check("midshift_reset_outputs",
            {bus.req_ready_o, bus.result_valid_o, bus.result_o, bus.zero_o,
             bus.overflow_o, bus.illegal_o, dbg_state},
            {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      repeat (45) @(negedge clk);   // any late pulse trips the monitor
      check("idle_after_abort", {dbg_state, bus.req_ready_o}, {1'b0, 1'b1});

      // ---- random back-to-back traffic against the model ----
      for (int i = 0; i < 40; i++) begin
         rc = ops[$urandom_range(0, 9)];
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
         if (rc == C_SLL) ra[5:0] = 6'($urandom_range(0, 7));
         lat = (rc == C_SLL) ? int'(ra[5:0]) : 0;
         send(rc, ra, rb, model(rc, ra, rb), lat, 1'b1);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
